// File: rtl/vc_scheduler.sv
// ============================================================================
//  Module      : vc_scheduler
//  Description : Credit-aware scheduler draining four virtual-channel FIFOs
//                (VC0/VC1 x port 0/1) onto two destination outputs. One pop
//                per cycle. Per-VC port round-robin, per-destination credits.
//                Optional macro ARB_WRR_EN selects weighted round-robin
//                between VCs; when undefined VC0 has strict priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_scheduler #(
    parameter int DATA_W  = 5,
    parameter int CREDITS = 4,
    parameter int W_VC0   = 3,
    parameter int W_VC1   = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] VC0_p0,
    input  logic [DATA_W-1:0] VC1_p0,
    input  logic [DATA_W-1:0] VC0_p1,
    input  logic [DATA_W-1:0] VC1_p1,
    input  logic              emptyVC0_p0,
    input  logic              emptyVC1_p0,
    input  logic              emptyVC0_p1,
    input  logic              emptyVC1_p1,
    input  logic              creditReturn_0,
    input  logic              creditReturn_1,
    output logic              popVC0_0,
    output logic              popVC1_0,
    output logic              popVC0_1,
    output logic              popVC1_1,
    output logic [DATA_W-1:0] dataOut_0,
    output logic [DATA_W-1:0] dataOut_1,
    output logic              validOut_0,
    output logic              validOut_1,
    output logic              creditErr
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

    logic [1:0][3:0] credit_q;
    logic [1:0][3:0] credit_d;
    logic            creditErr_q;
    logic            err_set_d;
    logic            rr0_q, rr1_q;

    logic e00, e01, e10, e11;        // eligibility: e<vc><port>
    logic vc0_el, vc1_el;
    logic vc0_port, vc1_port;
    logic gnt, gnt_vc, gnt_port, dest;
    logic [DATA_W-1:0] head;

    // A candidate is eligible when its FIFO has data and its destination has credit
    assign e00 = ~emptyVC0_p0 & (credit_q[VC0_p0[DATA_W-1]] != 4'd0);
    assign e01 = ~emptyVC0_p1 & (credit_q[VC0_p1[DATA_W-1]] != 4'd0);
    assign e10 = ~emptyVC1_p0 & (credit_q[VC1_p0[DATA_W-1]] != 4'd0);
    assign e11 = ~emptyVC1_p1 & (credit_q[VC1_p1[DATA_W-1]] != 4'd0);

    assign vc0_el = e00 | e01;
    assign vc1_el = e10 | e11;

    // Round-robin pointer only matters when both ports of a VC compete
    assign vc0_port = (e00 & e01) ? rr0_q : e01;
    assign vc1_port = (e10 & e11) ? rr1_q : e11;

    assign gnt = vc0_el | vc1_el;

`ifdef ARB_WRR_EN
    typedef enum logic {S_VC0 = 1'b0, S_VC1 = 1'b1} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_n;
    logic [3:0] weight;
    logic       state_vc;

    assign state_vc = (state_q == S_VC1);

    // Prefer the VC that owns the current turn, fall back to the other one
    always_comb begin
        gnt_vc = 1'b0;
        if (state_vc) gnt_vc = vc1_el ? 1'b1 : 1'b0;
        else          gnt_vc = vc0_el ? 1'b0 : 1'b1;
    end

    // Run length continues only when the grant stays on the turn owner
    assign cnt_n  = ((gnt_vc == state_vc) ? cnt_q : 4'd0) + 4'd1;
    assign weight = gnt_vc ? 4'(W_VC1) : 4'(W_VC0);

    // WRR turn state: hand the turn over once the granted VC used its weight
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_VC0;
            cnt_q   <= 4'd0;
        end else if (gnt) begin
            if (cnt_n == weight) begin
                state_q <= gnt_vc ? S_VC0 : S_VC1;
                cnt_q   <= 4'd0;
            end else begin
                state_q <= gnt_vc ? S_VC1 : S_VC0;
                cnt_q   <= cnt_n;
            end
        end
    end
`else
    logic unused_weights;

    // Strict priority: VC1 only wins when VC0 has nothing eligible
    assign gnt_vc = ~vc0_el;
    assign unused_weights = ^{4'(W_VC0), 4'(W_VC1)};
`endif

    assign gnt_port = gnt_vc ? vc1_port : vc0_port;

    // Head word of the granted candidate
    always_comb begin
        head = VC0_p0;
        case ({gnt_vc, gnt_port})
            2'b00:   head = VC0_p0;
            2'b01:   head = VC0_p1;
            2'b10:   head = VC1_p0;
            default: head = VC1_p1;
        endcase
    end

    assign dest = head[DATA_W-1];

    // Pops are combinational and forced low while reset is asserted
    assign popVC0_0 = reset_L & gnt & ~gnt_vc & ~gnt_port;
    assign popVC0_1 = reset_L & gnt & ~gnt_vc &  gnt_port;
    assign popVC1_0 = reset_L & gnt &  gnt_vc & ~gnt_port;
    assign popVC1_1 = reset_L & gnt &  gnt_vc &  gnt_port;

    // Next credit values: grant and return in the same cycle cancel out
    always_comb begin
        credit_d  = credit_q;
        err_set_d = 1'b0;
        for (int d = 0; d < 2; d++) begin
            logic inc, dec;
            inc = (d == 0) ? creditReturn_0 : creditReturn_1;
            dec = gnt & (dest == d[0]);
            if (inc && !dec) begin
                if (credit_q[d] == CREDIT_MAX) err_set_d = 1'b1;
                else                           credit_d[d] = credit_q[d] + 4'd1;
            end else if (dec && !inc) begin
                credit_d[d] = credit_q[d] - 4'd1;
            end
        end
    end

    // Credit counters, sticky error flag and port round-robin pointers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            credit_q    <= {CREDIT_MAX, CREDIT_MAX};
            creditErr_q <= 1'b0;
            rr0_q       <= 1'b0;
            rr1_q       <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            creditErr_q <= creditErr_q | err_set_d;
            if (gnt) begin
                if (gnt_vc) rr1_q <= ~gnt_port;
                else        rr0_q <= ~gnt_port;
            end
        end
    end

    // Register the granted word onto its destination; the other output holds
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dataOut_0  <= '0;
            dataOut_1  <= '0;
            validOut_0 <= 1'b0;
            validOut_1 <= 1'b0;
        end else begin
            validOut_0 <= gnt & ~dest;
            validOut_1 <= gnt &  dest;
            if (gnt && !dest) dataOut_0 <= {gnt_vc, head[DATA_W-2:0]};
            if (gnt &&  dest) dataOut_1 <= {gnt_vc, head[DATA_W-2:0]};
        end
    end

    assign creditErr = creditErr_q;

endmodule

`default_nettype wire

// File: tb/tb_vc_scheduler.sv
// ============================================================================
//  Module      : tb_vc_scheduler
//  Description : Directed self-checking bench for vc_scheduler. Expected
//                grant order follows ARB_WRR_EN when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_scheduler;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [4:0] VC0_p0, VC1_p0, VC0_p1, VC1_p1;
    logic       emptyVC0_p0, emptyVC1_p0, emptyVC0_p1, emptyVC1_p1;
    logic       creditReturn_0, creditReturn_1;
    logic       popVC0_0, popVC1_0, popVC0_1, popVC1_1;
    logic [4:0] dataOut_0, dataOut_1;
    logic       validOut_0, validOut_1;
    logic       creditErr;

    int vectors     = 0;
    int miscompares = 0;

    // Pop code: 1=VC0_p0, 2=VC1_p0, 4=VC0_p1, 8=VC1_p1
    wire [3:0] pops = {popVC1_1, popVC0_1, popVC1_0, popVC0_0};

    logic [3:0] exp_pop [8];
    logic [4:0] exp_data;

    vc_scheduler #(.DATA_W(5), .CREDITS(4), .W_VC0(3), .W_VC1(1)) dut (
        .clk(clk), .reset_L(reset_L),
        .VC0_p0(VC0_p0), .VC1_p0(VC1_p0), .VC0_p1(VC0_p1), .VC1_p1(VC1_p1),
        .emptyVC0_p0(emptyVC0_p0), .emptyVC1_p0(emptyVC1_p0),
        .emptyVC0_p1(emptyVC0_p1), .emptyVC1_p1(emptyVC1_p1),
        .creditReturn_0(creditReturn_0), .creditReturn_1(creditReturn_1),
        .popVC0_0(popVC0_0), .popVC1_0(popVC1_0),
        .popVC0_1(popVC0_1), .popVC1_1(popVC1_1),
        .dataOut_0(dataOut_0), .dataOut_1(dataOut_1),
        .validOut_0(validOut_0), .validOut_1(validOut_1),
        .creditErr(creditErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        emptyVC0_p0 = 1'b1; emptyVC1_p0 = 1'b1;
        emptyVC0_p1 = 1'b1; emptyVC1_p1 = 1'b1;
        creditReturn_0 = 1'b0; creditReturn_1 = 1'b0;
    endtask

    task automatic load_all_dest0();
        VC0_p0 = 5'h01; VC0_p1 = 5'h02; VC1_p0 = 5'h03; VC1_p1 = 5'h04;
        emptyVC0_p0 = 1'b0; emptyVC1_p0 = 1'b0;
        emptyVC0_p1 = 1'b0; emptyVC1_p1 = 1'b0;
    endtask

    // Assert reset for one cycle; returns at the releasing falling edge
    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    // Output word expected for a pop code of the all-dest-0 pattern
    function automatic logic [4:0] data_for(input logic [3:0] p);
        case (p)
            4'h1:    return 5'h01;
            4'h4:    return 5'h02;
            4'h2:    return 5'h13;
            default: return 5'h14;
        endcase
    endfunction

    initial begin
`ifdef ARB_WRR_EN
        exp_pop = '{4'h1, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h4, 4'h8};
`else
        exp_pop = '{4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4};
`endif
        reset_L = 1'b0;
        VC0_p0 = '0; VC1_p0 = '0; VC0_p1 = '0; VC1_p1 = '0;
        idle_inputs();

        // ---- reset state ----
        @(negedge clk); #1;
        chk("rst_pops", 8'(pops), 8'h0);
        chk("rst_data0", 8'(dataOut_0), 8'h0);
        chk("rst_data1", 8'(dataOut_1), 8'h0);
        chk("rst_valid", 8'({validOut_1, validOut_0}), 8'h0);
        chk("rst_err", 8'(creditErr), 8'h0);

        // ---- all four FIFOs busy, dest 0, credit returned every cycle ----
        @(negedge clk);
        reset_L = 1'b1;
        load_all_dest0();
        creditReturn_0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("seq_pop", 8'(pops), 8'(exp_pop[i]));
            if (i > 0) begin
                exp_data = data_for(exp_pop[i-1]);
                chk("seq_data0", 8'(dataOut_0), 8'(exp_data));
                chk("seq_valid", 8'({validOut_1, validOut_0}), 8'h1);
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("seq_pop_idle", 8'(pops), 8'h0);
        exp_data = data_for(exp_pop[7]);
        chk("seq_data0_last", 8'(dataOut_0), 8'(exp_data));
        @(negedge clk); #1;
        chk("seq_valid_idle", 8'({validOut_1, validOut_0}), 8'h0);
        chk("seq_no_err", 8'(creditErr), 8'h0);

        // ---- credit exhaustion on dest 1 ----
        do_reset();
        VC0_p0 = 5'h1A; emptyVC0_p0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cred_pop", 8'(pops), (i < 4) ? 8'h1 : 8'h0);
            if (i == 1) begin
                chk("cred_data1", 8'(dataOut_1), 8'h0A);
                chk("cred_valid", 8'({validOut_1, validOut_0}), 8'h2);
            end
            @(negedge clk);
        end
        creditReturn_1 = 1'b1;
        #1;
        chk("cret_same_cycle", 8'(pops), 8'h0);
        @(negedge clk);
        creditReturn_1 = 1'b0;
        #1;
        chk("cret_next_cycle", 8'(pops), 8'h1);
        @(negedge clk); #1;
        chk("cret_only_one", 8'(pops), 8'h0);
        chk("cret_valid1", 8'(validOut_1), 8'h1);
        chk("cret_no_err", 8'(creditErr), 8'h0);
        idle_inputs();

        // ---- dest 0 starved, VC1 to dest 1 still proceeds ----
        do_reset();
        VC0_p0 = 5'h05; emptyVC0_p0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain0_pop", 8'(pops), 8'h1);
            @(negedge clk);
        end
        #1;
        chk("starved_pop", 8'(pops), 8'h0);
        VC0_p1 = 5'h06; emptyVC0_p1 = 1'b0;
        VC1_p1 = 5'h17; emptyVC1_p1 = 1'b0;
        #1;
        chk("bypass_pop", 8'(pops), 8'h8);
        @(negedge clk); #1;
        chk("bypass_data1", 8'(dataOut_1), 8'h17);
        chk("bypass_valid", 8'({validOut_1, validOut_0}), 8'h2);
        chk("bypass_data0_hold", 8'(dataOut_0), 8'h05);
        idle_inputs();

        // ---- spurious credit return at full credit ----
        do_reset();
        creditReturn_0 = 1'b1;
        @(negedge clk);
        creditReturn_0 = 1'b0;
        #1;
        chk("err_set", 8'(creditErr), 8'h1);
        VC0_p0 = 5'h03; emptyVC0_p0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("err_sat_pop", 8'(pops), (i < 4) ? 8'h1 : 8'h0);
            @(negedge clk);
        end
        #1;
        chk("err_sticky", 8'(creditErr), 8'h1);
        idle_inputs();
        do_reset();
        #1;
        chk("err_cleared", 8'(creditErr), 8'h0);

        // ---- asynchronous reset mid-stream ----
        load_all_dest0();
        creditReturn_0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        chk("arst_pops", 8'(pops), 8'h0);
        chk("arst_data0", 8'(dataOut_0), 8'h0);
        chk("arst_valid", 8'({validOut_1, validOut_0}), 8'h0);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        chk("arst_first_pop", 8'(pops), 8'h1);
        @(negedge clk); #1;
        chk("arst_first_data", 8'(dataOut_0), 8'h01);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
